fetch_prefetch_buffer: RTL and testbench

- Instruction-fetch front end that drives the IF/ID pipeline register.
- Owns the fetch PC and issues word requests to a variable-latency instruction memory port.
- Buffers returned instructions, each with its PC+4, in an in-order FIFO.
- Honours decode stalls and branch/jump redirects from the MEM-stage PC-source logic, discarding any in-flight wrong-path fetches.

---
 rtl/fetch_prefetch_buffer.sv | 146 ++++++++++++++
 tb/tb_fetch_prefetch_buffer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_buffer.sv
// Instruction-fetch front end with an in-order prefetch FIFO.
// Issues word fetches, buffers responses with PC+4, and flushes on redirect.
//
// Ports:
//   Clk, Reset       clock (rising) and async active-low reset
//   Stall            decode busy, hold the head entry
//   Redirect/PC      taken branch/jump: flush and refetch from RedirectPC
//   IMemReq/Addr/Gnt request handshake to the instruction memory
//   IMemRValid/RData in-order read responses
//   IFIDValid/...    head of FIFO presented to the IF/ID register
//   Count            FIFO occupancy, 0..DEPTH
module fetch_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Stall,
  input  logic                     Redirect,
  input  logic [31:0]              RedirectPC,
  output logic                     IMemReq,
  output logic [31:0]              IMemAddr,
  input  logic                     IMemGnt,
  input  logic                     IMemRValid,
  input  logic [31:0]              IMemRData,
  output logic                     IFIDValid,
  output logic [31:0]              IFIDInstruction,
  output logic [31:0]              IFIDPCPlus4,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t        state;
  logic [31:0]   fetchPC;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] pcRdPtr;
  logic [PW-1:0] pcWrPtr;

  logic [31:0] instrMem [DEPTH];
  logic [31:0] pcp4Mem  [DEPTH];
  logic [31:0] pcMem    [DEPTH];

  logic          credit;
  logic          grant;
  logic          drop;
  logic          push;
  logic          pop;
  logic [CW-1:0] redirDiscard;
  logic [31:0]   alignedPC;

  // Buffered plus in-flight words may never exceed the FIFO size,
  // so every response is guaranteed a free slot.
  assign credit = ({1'b0, count} + {1'b0, outstanding})
                < (CW+1)'(DEPTH);

  assign IMemReq  = (state == RUN) && credit && !Redirect;
  assign IMemAddr = fetchPC;
  assign grant    = IMemReq && IMemGnt;

  assign drop = IMemRValid && (discard != '0);
  assign push = IMemRValid && (discard == '0) && !Redirect;
  assign pop  = IFIDValid && !Stall && !Redirect;

  // Everything still in flight after this cycle belongs to the old path.
  assign redirDiscard = outstanding + CW'(grant) - CW'(IMemRValid);
  assign alignedPC    = RedirectPC & 32'hFFFF_FFFC;

  assign IFIDValid       = (count != '0);
  assign IFIDInstruction = IFIDValid ? instrMem[rdPtr] : '0;
  assign IFIDPCPlus4     = IFIDValid ? pcp4Mem[rdPtr] : '0;
  assign Count           = count;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      fetchPC     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      rdPtr       <= '0;
      wrPtr       <= '0;
    end else if (Redirect) begin
      fetchPC     <= alignedPC;
      outstanding <= redirDiscard;
      discard     <= redirDiscard;
      count       <= '0;
      rdPtr       <= '0;
      wrPtr       <= '0;
      state       <= (redirDiscard != '0) ? FLUSH : RUN;
    end else begin
      unique case (state)
        IDLE: state <= RUN;
        RUN, FLUSH: begin
          if (grant)
            fetchPC <= fetchPC + 32'd4;
          outstanding <= outstanding + CW'(grant)
                       - CW'(IMemRValid);
          if (drop)
            discard <= discard - 1'b1;
          if (state == FLUSH && drop && discard == CW'(1))
            state <= RUN;
          if (push)
            wrPtr <= wrPtr + 1'b1;
          if (pop)
            rdPtr <= rdPtr + 1'b1;
          count <= count + CW'(push) - CW'(pop);
        end
      endcase
    end
  end

  // Granted addresses, retired one per response (kept or dropped).
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pcRdPtr <= '0;
      pcWrPtr <= '0;
    end else begin
      if (grant)
        pcWrPtr <= pcWrPtr + 1'b1;
      if (IMemRValid)
        pcRdPtr <= pcRdPtr + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (grant)
      pcMem[pcWrPtr] <= fetchPC;
    if (push) begin
      instrMem[wrPtr] <= IMemRData;
      pcp4Mem[wrPtr]  <= pcMem[pcRdPtr] + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Bench for fetch_prefetch_buffer: random memory timing against a
// program-order model with epoch-tagged in-flight requests.
module tb_fetch_prefetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        Clk = 0;
  logic        Reset = 1;
  logic        Stall = 0;
  logic        Redirect = 0;
  logic [31:0] RedirectPC = 0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemGnt = 0;
  logic        IMemRValid = 0;
  logic [31:0] IMemRData = 0;
  logic        IFIDValid;
  logic [31:0] IFIDInstruction;
  logic [31:0] IFIDPCPlus4;
  logic [2:0]  Count;

  fetch_prefetch_buffer #(
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Stall(Stall),
    .Redirect(Redirect),
    .RedirectPC(RedirectPC),
    .IMemReq(IMemReq),
    .IMemAddr(IMemAddr),
    .IMemGnt(IMemGnt),
    .IMemRValid(IMemRValid),
    .IMemRData(IMemRData),
    .IFIDValid(IFIDValid),
    .IFIDInstruction(IFIDInstruction),
    .IFIDPCPlus4(IFIDPCPlus4),
    .Count(Count)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } req_t;

  req_t        respQ[$];
  logic [31:0] fifoQ[$];
  logic [31:0] mPC = RESET_PC;
  int          epoch = 0;
  int          cyc = 0;
  bit          idle = 1;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction

  // One clock of stimulus plus model comparison; entered and left at
  // 1 time unit after a rising edge.
  task automatic step(input bit st, input bit rd,
                      input logic [31:0] rpc,
                      input int gntPct, input int lat);
    bit   rv;
    bit   gnt;
    bit   expReq;
    bit   pop;
    int   cur;
    int   old;
    req_t r;
    req_t n;
    cur = 0;
    old = 0;
    foreach (respQ[i]) begin
      if (respQ[i].ep == epoch) cur++;
      else old++;
    end
    rv  = respQ.size() > 0 && respQ[0].due <= cyc;
    gnt = $urandom_range(0, 99) < gntPct;
    Stall      = st;
    Redirect   = rd;
    RedirectPC = rpc;
    IMemGnt    = gnt;
    IMemRValid = rv;
    IMemRData  = rv ? memWord(respQ[0].addr) : $urandom;
    #1;
    expReq = !idle && !rd && old == 0
          && (fifoQ.size() + cur) < DEPTH;
    total++;
    if (IMemReq !== expReq) begin
      bad++;
      $display("FAIL req cyc=%0d got=%b want=%b",
               cyc, IMemReq, expReq);
    end
    if (expReq) begin
      total++;
      if (IMemAddr !== mPC) begin
        bad++;
        $display("FAIL addr cyc=%0d got=%h want=%h",
                 cyc, IMemAddr, mPC);
      end
    end
    total++;
    if (Count !== 3'(fifoQ.size())) begin
      bad++;
      $display("FAIL count cyc=%0d got=%0d want=%0d",
               cyc, Count, fifoQ.size());
    end
    total++;
    if (IFIDValid !== (fifoQ.size() != 0)) begin
      bad++;
      $display("FAIL valid cyc=%0d got=%b want=%b",
               cyc, IFIDValid, fifoQ.size() != 0);
    end
    if (fifoQ.size() > 0) begin
      total++;
      if (IFIDPCPlus4 !== fifoQ[0] + 32'd4 ||
          IFIDInstruction !== memWord(fifoQ[0])) begin
        bad++;
        $display("FAIL head cyc=%0d got=%h/%h want=%h/%h",
                 cyc, IFIDPCPlus4, IFIDInstruction,
                 fifoQ[0] + 32'd4, memWord(fifoQ[0]));
      end
    end
    pop = fifoQ.size() > 0 && !st && !rd;
    @(posedge Clk);
    r = '{addr: 0, due: 0, ep: -1};
    if (rv) r = respQ.pop_front();
    if (rd) begin
      fifoQ.delete();
      epoch++;
      mPC = rpc & 32'hFFFF_FFFC;
    end else begin
      if (pop) fifoQ.delete(0);
      if (rv && r.ep == epoch) fifoQ.push_back(r.addr);
      if (expReq && gnt) begin
        n.addr = mPC;
        n.due  = cyc + lat;
        n.ep   = epoch;
        respQ.push_back(n);
        mPC = mPC + 32'd4;
      end
    end
    idle = 0;
    cyc++;
    #1;
  endtask

  task automatic doReset();
    Reset      = 0;
    Stall      = 0;
    Redirect   = 0;
    IMemGnt    = 0;
    IMemRValid = 0;
    #1;
    total++;
    if (IMemReq !== 1'b0 || IFIDValid !== 1'b0 || Count !== 3'd0) begin
      bad++;
      $display("FAIL rst_ctl got req=%b valid=%b count=%0d want 0/0/0",
               IMemReq, IFIDValid, Count);
    end
    total++;
    if (IFIDInstruction !== 32'h0 || IFIDPCPlus4 !== 32'h0) begin
      bad++;
      $display("FAIL rst_data got %h/%h want 0/0",
               IFIDInstruction, IFIDPCPlus4);
    end
    respQ.delete();
    fifoQ.delete();
    mPC   = RESET_PC;
    idle  = 1;
    epoch++;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1;
  endtask

  task automatic test_reset();
    #2;
    doReset();
    step(0, 0, 0, 100, 1);
    total++;
    if (IMemReq !== 1'b1 || IMemAddr !== RESET_PC) begin
      bad++;
      $display("FAIL first_fetch got req=%b addr=%h want 1/%h",
               IMemReq, IMemAddr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 20; i++) step(0, 0, 0, 100, 1);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 10; i++) step(1, 0, 0, 100, 1);
    total++;
    if (Count !== 3'(DEPTH) || IMemReq !== 1'b0) begin
      bad++;
      $display("FAIL stall_full got count=%0d req=%b want %0d/0",
               Count, IMemReq, DEPTH);
    end
    for (int i = 0; i < 12; i++) step(0, 0, 0, 100, 1);
  endtask

  task automatic test_redirect();
    int k;
    k = 0;
    while (respQ.size() < 3 && k < 20) begin
      step(0, 0, 0, 100, 3);
      k++;
    end
    total++;
    if (respQ.size() < 3) begin
      bad++;
      $display("FAIL inflight3 got=%0d want>=3", respQ.size());
    end
    step(0, 1, 32'h100, 100, 3);
    total++;
    if (Count !== 3'd0 || IFIDValid !== 1'b0) begin
      bad++;
      $display("FAIL redir_empty got count=%0d valid=%b want 0/0",
               Count, IFIDValid);
    end
    k = 0;
    while (!IFIDValid && k < 30) begin
      step(0, 0, 0, 100, 3);
      k++;
    end
    total++;
    if (IFIDValid !== 1'b1 || IFIDPCPlus4 !== 32'h104) begin
      bad++;
      $display("FAIL redir_first got valid=%b pc4=%h want 1/104",
               IFIDValid, IFIDPCPlus4);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 100, 3);
  endtask

  task automatic test_collision();
    int k;
    k = 0;
    while (!(respQ.size() > 0 && respQ[0].due <= cyc) && k < 10) begin
      step(0, 0, 0, 100, 1);
      k++;
    end
    total++;
    if (!(respQ.size() > 0 && respQ[0].due <= cyc)) begin
      bad++;
      $display("FAIL collide_setup got none want pending response");
    end
    step(0, 1, 32'h200, 100, 1);
    total++;
    if (Count !== 3'd0) begin
      bad++;
      $display("FAIL collide_empty got count=%0d want 0", Count);
    end
    for (int i = 0; i < 12; i++) step(0, 0, 0, 100, 1);
  endtask

  task automatic test_no_grant();
    logic [31:0] pcBefore;
    pcBefore = mPC;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    total++;
    if (IMemReq !== 1'b1 || IMemAddr !== pcBefore) begin
      bad++;
      $display("FAIL hold got req=%b addr=%h want 1/%h",
               IMemReq, IMemAddr, pcBefore);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 100, 2);
  endtask

  task automatic test_reset_flush();
    int k;
    k = 0;
    while (!(respQ.size() >= 2 && respQ[0].due > cyc) && k < 20) begin
      step(0, 0, 0, 100, 3);
      k++;
    end
    total++;
    if (!(respQ.size() >= 2 && respQ[0].due > cyc)) begin
      bad++;
      $display("FAIL flush_setup got inflight=%0d want>=2", respQ.size());
    end
    step(0, 1, 32'h300, 100, 3);
    doReset();
    step(0, 0, 0, 100, 2);
    total++;
    if (IMemReq !== 1'b1 || IMemAddr !== RESET_PC) begin
      bad++;
      $display("FAIL restart got req=%b addr=%h want 1/%h",
               IMemReq, IMemAddr, RESET_PC);
    end
    for (int i = 0; i < 15; i++) step(0, 0, 0, 100, 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0,
           $urandom_range(0, 19) == 0,
           $urandom,
           60,
           $urandom_range(1, 4));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_collision();
    test_no_grant();
    test_reset_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
